// File: rtl/debounce_one_shot_if.sv
// Button-side signal bundle for debounce_one_shot: raw button in, debounced
// level and interrupt pulse out.
interface debounce_one_shot_if;
  logic BTN;
  logic DB_OUT;
  logic ONE_SHOT;

  modport master (output BTN, input DB_OUT, input ONE_SHOT);
  modport slave  (input BTN, output DB_OUT, output ONE_SHOT);
endinterface

// File: rtl/debounce_one_shot.sv
// Pushbutton debouncer with a fixed-width one-shot interrupt pulse per accepted press.
// The raw button is double-flopped, then a Moore FSM qualifies press and release edges.
module debounce_one_shot #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ONESHOT_LEN     = 2
) (
  input  logic                CLK,
  input  logic                RST,
  debounce_one_shot_if.slave  bus
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PCW = $clog2(ONESHOT_LEN + 1);
  localparam logic [DCW-1:0] DC_MAX = DCW'(DEBOUNCE_CYCLES);
  localparam logic [PCW-1:0] PL_MAX = PCW'(ONESHOT_LEN);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PULSE,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t         state_reg;
  logic           s1_reg;
  logic           s2_reg;
  logic [DCW-1:0] cnt_reg;
  logic [PCW-1:0] pcnt_reg;
  logic           db_out_reg;
  logic           one_shot_reg;

  // Outputs are updated alongside the state so they match the state just entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      cnt_reg      <= '0;
      pcnt_reg     <= '0;
      db_out_reg   <= 1'b0;
      one_shot_reg <= 1'b0;
    end else begin
      s1_reg <= bus.BTN;
      s2_reg <= s1_reg;

      case (state_reg)
        IDLE: begin
          if (s2_reg) begin
            state_reg <= PRESS_WAIT;
            cnt_reg   <= DCW'(1);
          end
        end

        PRESS_WAIT: begin
          if (!s2_reg) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == DC_MAX) begin
            state_reg    <= PULSE;
            cnt_reg      <= '0;
            pcnt_reg     <= PCW'(1);
            one_shot_reg <= 1'b1;
            db_out_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + DCW'(1);
          end
        end

        // Input is deliberately ignored here so the pulse always runs full width.
        PULSE: begin
          if (pcnt_reg == PL_MAX) begin
            state_reg    <= HELD;
            pcnt_reg     <= '0;
            one_shot_reg <= 1'b0;
          end else begin
            pcnt_reg <= pcnt_reg + PCW'(1);
          end
        end

        HELD: begin
          if (!s2_reg) begin
            state_reg <= RELEASE_WAIT;
            cnt_reg   <= DCW'(1);
          end
        end

        RELEASE_WAIT: begin
          if (s2_reg) begin
            state_reg <= HELD;
            cnt_reg   <= '0;
          end else if (cnt_reg == DC_MAX) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            db_out_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + DCW'(1);
          end
        end

        default: begin
          state_reg    <= IDLE;
          cnt_reg      <= '0;
          pcnt_reg     <= '0;
          db_out_reg   <= 1'b0;
          one_shot_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DB_OUT   = db_out_reg;
  assign bus.ONE_SHOT = one_shot_reg;

endmodule

// File: tb/tb_debounce_one_shot.sv
// Directed bench for debounce_one_shot with DEBOUNCE_CYCLES=4, ONESHOT_LEN=2.
// Expected outputs are hand-derived edge indices relative to the first edge sampling a new BTN level.
module tb_debounce_one_shot;

  localparam int DC = 4;
  localparam int OL = 2;

  logic CLK = 1'b0;
  logic RST;

  debounce_one_shot_if bus ();

  debounce_one_shot #(
    .DEBOUNCE_CYCLES (DC),
    .ONESHOT_LEN     (OL)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive BTN, let one rising edge sample it, then settle 1 ns past the edge.
  task automatic step(input logic b);
    bus.BTN = b;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int pulses;
    int hi_cycles;
    logic prev_os;

    // Reset with BTN high: everything must stay cleared.
    RST = 1'b1;
    bus.BTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check($sformatf("rst%0d.os", i), bus.ONE_SHOT, 0);
      check($sformatf("rst%0d.db", i), bus.DB_OUT, 0);
    end
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      check($sformatf("idle%0d.os", i), bus.ONE_SHOT, 0);
    end
    $display("reset: outputs held low");

    // Clean press held 300 ns: pulse after edges 6 and 7, no retrigger.
    for (int i = 0; i < 30; i++) begin
      step(1'b1);
      check($sformatf("press%0d.os", i), bus.ONE_SHOT, (i == 6 || i == 7) ? 1 : 0);
      check($sformatf("press%0d.db", i), bus.DB_OUT, (i >= 6) ? 1 : 0);
    end
    $display("clean press: pulse at edges 6,7");

    // Release bounce of two clocks: stays held, no second pulse.
    for (int i = 0; i < 8; i++) begin
      step((i < 2) ? 1'b0 : 1'b1);
      check($sformatf("rbounce%0d.os", i), bus.ONE_SHOT, 0);
      check($sformatf("rbounce%0d.db", i), bus.DB_OUT, 1);
    end
    $display("release bounce: DB_OUT kept high");

    // Clean release: DB_OUT falls after edge R+6.
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      check($sformatf("release%0d.os", i), bus.ONE_SHOT, 0);
      check($sformatf("release%0d.db", i), bus.DB_OUT, (i < 6) ? 1 : 0);
    end
    $display("release: DB_OUT low after edge R+6");

    // Glitch three clocks wide: nothing happens.
    for (int i = 0; i < 13; i++) begin
      step((i < 3) ? 1'b1 : 1'b0);
      check($sformatf("glitch%0d.os", i), bus.ONE_SHOT, 0);
      check($sformatf("glitch%0d.db", i), bus.DB_OUT, 0);
    end
    $display("glitch: no output");

    // Press bounce 1,0,1,1,0 then stable high from index 5: pulse at 11,12.
    for (int i = 0; i < 25; i++) begin
      logic b;
      case (i)
        1, 4:    b = 1'b0;
        default: b = 1'b1;
      endcase
      step(b);
      check($sformatf("bounce%0d.os", i), bus.ONE_SHOT, (i == 11 || i == 12) ? 1 : 0);
      check($sformatf("bounce%0d.db", i), bus.DB_OUT, (i >= 11) ? 1 : 0);
    end
    for (int i = 0; i < 10; i++) step(1'b0);
    check("bounce.release.db", bus.DB_OUT, 0);
    $display("press bounce: single pulse after stable start");

    // Three presses, 100 ns wide, 300 ns apart.
    pulses = 0;
    hi_cycles = 0;
    prev_os = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 30; k++) begin
        step((k < 10) ? 1'b1 : 1'b0);
        check($sformatf("multi%0d.%0d.os", p, k), bus.ONE_SHOT, (k == 6 || k == 7) ? 1 : 0);
        if (bus.ONE_SHOT && !prev_os) pulses++;
        if (bus.ONE_SHOT) hi_cycles++;
        prev_os = bus.ONE_SHOT;
      end
    end
    check("multi.pulses", pulses, 3);
    check("multi.hi_cycles", hi_cycles, 6);
    $display("three presses: %0d pulses, %0d high cycles", pulses, hi_cycles);

    // Reset in the middle of a pulse with BTN held, then a full new debounce.
    for (int i = 0; i < 7; i++) step(1'b1);
    check("rpulse.pre.os", bus.ONE_SHOT, 1);
    RST = 1'b1;
    step(1'b1);
    check("rpulse.rst.os", bus.ONE_SHOT, 0);
    check("rpulse.rst.db", bus.DB_OUT, 0);
    RST = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step(1'b1);
      check($sformatf("rpulse%0d.os", i), bus.ONE_SHOT, (i == 6 || i == 7) ? 1 : 0);
      check($sformatf("rpulse%0d.db", i), bus.DB_OUT, (i >= 6) ? 1 : 0);
    end
    $display("reset mid-pulse: truncated, new pulse at edges 6,7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_one_shot.md
DEBOUNCE_ONE_SHOT -- requirements
Module: debounce_one_shot

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable synchronized samples required to accept an edge; SHALL be >= 1.
REQ-002 Parameter ONESHOT_LEN, default 2, width in clocks of each interrupt pulse; SHALL be >= 1.
REQ-003 Port CLK  input  1  system clock; all state SHALL update on the rising edge only.
REQ-004 Port RST  input  1  reset, synchronous and active-high.
REQ-005 Port BTN  input  1  raw, asynchronous, bouncing pushbutton level (e.g. BTNL).
REQ-006 Port DB_OUT  output  1  debounced button level.
REQ-007 Port ONE_SHOT  output  1  interrupt request pulse for the RAT INTR input, ONESHOT_LEN clocks wide per accepted press.

Function
REQ-008 BTN SHALL pass through a two-flop synchronizer (s1, s2); the FSM SHALL sample only s2.
REQ-009 FSM states SHALL be IDLE, PRESS_WAIT, PULSE, HELD, RELEASE_WAIT.
REQ-010 Debounce counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide; pulse counter SHALL be $clog2(ONESHOT_LEN+1) bits wide; neither SHALL wrap.
REQ-011 IDLE: s2=1 -> PRESS_WAIT, counter=1; else stay.
REQ-012 PRESS_WAIT: s2=0 -> IDLE, counter=0; s2=1 and counter==DEBOUNCE_CYCLES -> PULSE, pulse counter=1; else counter+1.
REQ-013 PULSE: pulse counter==ONESHOT_LEN -> HELD; else pulse counter+1; s2 SHALL be ignored in PULSE (pulse always completes full width).
REQ-014 HELD: s2=0 -> RELEASE_WAIT, counter=1; else stay.
REQ-015 RELEASE_WAIT: s2=1 -> HELD, counter=0; s2=0 and counter==DEBOUNCE_CYCLES -> IDLE; else counter+1.
REQ-016 Outputs SHALL be registered Moore outputs: ONE_SHOT=1 only in PULSE; DB_OUT=1 in PULSE, HELD, RELEASE_WAIT.
REQ-017 With BTN stable high from edge E (first edge sampling BTN=1), ONE_SHOT and DB_OUT SHALL rise after edge E+DEBOUNCE_CYCLES+2.
REQ-018 With BTN stable low from edge E while in HELD, DB_OUT SHALL fall after edge E+DEBOUNCE_CYCLES+2.
REQ-019 Press glitch shorter than DEBOUNCE_CYCLES consecutive s2 samples SHALL produce no ONE_SHOT and no DB_OUT change.
REQ-020 Exactly one ONE_SHOT pulse SHALL occur per accepted press; holding BTN indefinitely SHALL NOT re-trigger.
REQ-021 Release bounce shorter than DEBOUNCE_CYCLES SHALL keep DB_OUT=1 and SHALL NOT produce a second pulse.
REQ-022 Release during PULSE: pulse SHALL complete, then HELD SHALL observe s2=0 and begin release debounce.

Reset
REQ-023 RST=1 at a rising edge SHALL force state=IDLE, s1=s2=0, both counters=0, DB_OUT=0, ONE_SHOT=0 after that edge, overriding all other conditions.
REQ-024 Reset mid-PULSE SHALL truncate the pulse (ONE_SHOT=0 after the reset edge); if BTN is still high after RST deasserts, a full new debounce SHALL run and yield one new pulse.

Verification (DEBOUNCE_CYCLES=4, ONESHOT_LEN=2, CLK period 10 ns)
REQ-025 Clean press: BTN 0->1 sampled at edge 0, held 300 ns -> ONE_SHOT=1 after edges 6 and 7 only, DB_OUT=1 from edge 6.
REQ-026 Bounce: BTN toggles 1,0,1,1,0 per clock then stays 1 -> no pulse during bounce; exactly one 2-clock pulse 6 edges after final stable-high start.
REQ-027 Glitch: BTN high 3 clocks then low -> ONE_SHOT and DB_OUT remain 0 throughout.
REQ-028 Release: from HELD, BTN low sampled at edge R, held -> DB_OUT=0 after edge R+6, ONE_SHOT stays 0; release bounce of 2 clocks keeps DB_OUT=1.
REQ-029 Three presses 300 ns apart, each 100 ns wide -> exactly three 2-clock ONE_SHOT pulses.
REQ-030 RST asserted one clock during PULSE with BTN held -> ONE_SHOT=0 after reset edge, then new pulse 6 edges after first post-reset edge sampling BTN=1.
